// File: rtl/qnn_result_streamer_if.sv
// Accelerator-capture and output-stream signals of the QNN result streamer.
// The master modport is the streamer's side of the link.
interface qnn_result_streamer_if #(
  parameter int OUT_DIM = 16,
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 8
);
  localparam int IDX_W = $clog2(OUT_DIM);

  logic                              acc_done;
  logic [OUT_DIM-1:0][ACC_W-1:0]     acc_out;
  logic                              relu_en;
  logic [4:0]                        shift;
  logic                              m_valid;
  logic                              m_ready;
  logic signed [OUT_W-1:0]           m_data;
  logic [IDX_W-1:0]                  m_idx;
  logic                              m_last;
  logic                              busy;
  logic                              overrun;

  modport master (
    input  acc_done, acc_out, relu_en, shift, m_ready,
    output m_valid, m_data, m_idx, m_last, busy, overrun
  );

  modport slave (
    output acc_done, acc_out, relu_en, shift, m_ready,
    input  m_valid, m_data, m_idx, m_last, busy, overrun
  );
endinterface

// File: rtl/qnn_result_streamer.sv
// Captures a QNN accumulator frame on acc_done, requantizes every element in
// parallel and streams the narrow results one per beat over valid/ready.
module qnn_result_streamer #(
  parameter int OUT_DIM = 16,
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  qnn_result_streamer_if.master bus
);
  localparam int IDX_W = $clog2(OUT_DIM);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_DIM - 1);
  localparam logic signed [ACC_W:0] SAT_MAX =
    {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN =
    {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t                  state_q;
  logic [IDX_W-1:0]        idx_q;
  logic                    overrun_q;
  logic signed [OUT_W-1:0] qbuf_q [OUT_DIM];
  logic signed [OUT_W-1:0] qbuf_d [OUT_DIM];
  logic                    hs;
  logic                    at_last;

  // One extra bit of headroom so the rounding bias can never wrap.
  function automatic logic signed [ACC_W:0] round_shift(
    input logic signed [ACC_W-1:0] x,
    input logic [4:0]              sh
  );
    logic signed [ACC_W:0] xe;
    logic signed [ACC_W:0] bias;
    xe = {x[ACC_W-1], x};
    if (sh == 5'd0) return xe;
    bias = (ACC_W+1)'(1) << (sh - 5'd1);
    return (xe + bias) >>> sh;
  endfunction

  function automatic logic signed [OUT_W-1:0] saturate(
    input logic signed [ACC_W:0] r,
    input logic                  relu
  );
    logic signed [ACC_W:0] v;
    v = r;
    if (relu && (v < 0)) v = '0;
    if (v > SAT_MAX) return SAT_MAX[OUT_W-1:0];
    if (v < SAT_MIN) return SAT_MIN[OUT_W-1:0];
    return v[OUT_W-1:0];
  endfunction

  always_comb begin
    for (int k = 0; k < OUT_DIM; k++) begin
      qbuf_d[k] = saturate(round_shift($signed(bus.acc_out[k]), bus.shift),
                           bus.relu_en);
    end
  end

  assign hs      = (state_q == STREAM) && bus.m_ready;
  assign at_last = (idx_q == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      overrun_q <= 1'b0;
      qbuf_q    <= '{default: '0};
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.acc_done) begin
            qbuf_q  <= qbuf_d;
            idx_q   <= '0;
            state_q <= STREAM;
          end
        end
        STREAM: begin
          // A frame arriving on the closing handshake chains on with no bubble.
          if (hs && at_last) begin
            idx_q <= '0;
            if (bus.acc_done) qbuf_q  <= qbuf_d;
            else              state_q <= IDLE;
          end else begin
            if (hs)           idx_q     <= idx_q + 1'b1;
            if (bus.acc_done) overrun_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.m_valid = (state_q == STREAM);
  assign bus.m_data  = qbuf_q[idx_q];
  assign bus.m_idx   = idx_q;
  assign bus.m_last  = (state_q == STREAM) && at_last;
  assign bus.busy    = (state_q == STREAM);
  assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_qnn_result_streamer.sv
// Randomized bench for qnn_result_streamer against an arithmetic requantization
// model and a beat scoreboard.
module tb_qnn_result_streamer;
  localparam int OUT_DIM = 16;
  localparam int ACC_W   = 32;
  localparam int OUT_W   = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  qnn_result_streamer_if #(.OUT_DIM(OUT_DIM), .ACC_W(ACC_W), .OUT_W(OUT_W)) bus();

  qnn_result_streamer #(.OUT_DIM(OUT_DIM), .ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int exp_d[$];
  int exp_i[$];
  int seen[OUT_DIM];
  int fr[OUT_DIM];
  int fr_shift;
  bit fr_relu;
  bit prev_stall;
  int prev_d, prev_i;

  task automatic chk_eq(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int ref_q(input longint x, input int sh, input bit relu);
    longint r, hi, lo;
    hi = (longint'(1) << (OUT_W - 1)) - 1;
    lo = -(longint'(1) << (OUT_W - 1));
    if (sh == 0) r = x;
    else         r = (x + (longint'(1) << (sh - 1))) >>> sh;
    if (relu && r < 0) r = 0;
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return int'(r);
  endfunction

  // Scoreboard and stall-stability monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk_eq("stall_valid", bus.m_valid, 1);
        chk_eq("stall_data", bus.m_data, prev_d);
        chk_eq("stall_idx", bus.m_idx, prev_i);
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_d.size() == 0) begin
          chk_eq("beat_unexpected", exp_d.size(), 1);
        end else begin
          int ed, ei;
          ed = exp_d.pop_front();
          ei = exp_i.pop_front();
          chk_eq("beat_data", bus.m_data, ed);
          chk_eq("beat_idx", bus.m_idx, ei);
          chk_eq("beat_last", bus.m_last, (ei == OUT_DIM - 1) ? 1 : 0);
        end
        seen[bus.m_idx] = bus.m_data;
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_d     = bus.m_data;
      prev_i     = bus.m_idx;
    end
  end

  task automatic rand_frame();
    for (int k = 0; k < OUT_DIM; k++) begin
      fr[k] = $urandom;
      if ($urandom_range(0, 1) == 1) fr[k] = fr[k] >>> $urandom_range(0, 24);
    end
    fr_shift = $urandom_range(0, 31);
    fr_relu  = 1'($urandom_range(0, 1));
  endtask

  // Called just after a clock edge; drives acc_done for one cycle.
  task automatic pulse_frame(input bit accept);
    for (int k = 0; k < OUT_DIM; k++) bus.acc_out[k] = fr[k];
    bus.shift    = fr_shift[4:0];
    bus.relu_en  = fr_relu;
    bus.acc_done = 1'b1;
    if (accept) begin
      for (int k = 0; k < OUT_DIM; k++) begin
        exp_d.push_back(ref_q(fr[k], fr_shift, fr_relu));
        exp_i.push_back(k);
      end
    end
    @(posedge clk); #1;
    bus.acc_done = 1'b0;
  endtask

  task automatic wait_idx(input int target);
    bit hit = 1'b0;
    for (int c = 0; c < 64 && !hit; c++) begin
      if (bus.m_valid && bus.m_idx == target) hit = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!hit) chk_eq("wait_idx", bus.m_idx, target);
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      if (!bus.busy) done = 1'b1;
      else begin @(posedge clk); #1; end
    end
    if (!done) chk_eq("wait_idle", bus.busy, 0);
    chk_eq("sb_drained", exp_d.size(), 0);
  endtask

  initial begin
    int cnt, hd;
    rst          = 1'b1;
    bus.acc_done = 1'b0;
    bus.acc_out  = '0;
    bus.relu_en  = 1'b0;
    bus.shift    = '0;
    bus.m_ready  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_valid", bus.m_valid, 0);
    chk_eq("rst_data", bus.m_data, 0);
    chk_eq("rst_idx", bus.m_idx, 0);
    chk_eq("rst_last", bus.m_last, 0);
    chk_eq("rst_busy", bus.busy, 0);
    chk_eq("rst_overrun", bus.overrun, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic frame: k*256 >> 8 yields k on beat k
    for (int k = 0; k < OUT_DIM; k++) fr[k] = k * 256;
    fr_shift = 8;
    fr_relu  = 1'b0;
    pulse_frame(1'b1);
    chk_eq("lat_valid", bus.m_valid, 1);
    chk_eq("lat_idx", bus.m_idx, 0);
    chk_eq("lat_last", bus.m_last, 0);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.busy) cnt++;
      else break;
    end
    chk_eq("busy_cycles", cnt, OUT_DIM);
    chk_eq("basic_beat3", seen[3], 3);
    chk_eq("basic_beat15", seen[15], 15);
    @(posedge clk); #1;
    chk_eq("sb_drained", exp_d.size(), 0);

    // Rounding, saturation and ReLU corner values
    for (int rl = 0; rl < 2; rl++) begin
      rand_frame();
      fr[0] = 384; fr[1] = -384; fr_shift = 8; fr_relu = 1'(rl);
      pulse_frame(1'b1);
      wait_idle();
      chk_eq("round_pos", seen[0], 2);
      chk_eq("round_neg", seen[1], (rl == 1) ? 0 : -1);
      rand_frame();
      fr[2] = 100000; fr[3] = -100000; fr[4] = -5; fr_shift = 0; fr_relu = 1'(rl);
      pulse_frame(1'b1);
      wait_idle();
      chk_eq("sat_pos", seen[2], 127);
      chk_eq("sat_neg", seen[3], (rl == 1) ? 0 : -128);
      chk_eq("small_neg", seen[4], (rl == 1) ? 0 : -5);
    end

    // Backpressure at beat 5
    rand_frame();
    pulse_frame(1'b1);
    wait_idx(5);
    bus.m_ready = 1'b0;
    hd = (exp_d.size() > 0) ? exp_d[0] : 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_eq("bp_valid", bus.m_valid, 1);
      chk_eq("bp_idx", bus.m_idx, 5);
      chk_eq("bp_data", bus.m_data, hd);
      @(posedge clk); #1;
    end
    bus.m_ready = 1'b1;
    wait_idle();

    // Random backpressure with mid-frame shift/relu churn
    repeat (4) begin
      rand_frame();
      pulse_frame(1'b1);
      for (int c = 0; c < 400 && bus.busy; c++) begin
        bus.m_ready = 1'($urandom_range(0, 1));
        bus.shift   = 5'($urandom);
        bus.relu_en = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      bus.m_ready = 1'b1;
      wait_idle();
    end

    // Back-to-back frame on the final handshake
    rand_frame();
    pulse_frame(1'b1);
    wait_idx(15);
    rand_frame();
    pulse_frame(1'b1);
    chk_eq("b2b_valid", bus.m_valid, 1);
    chk_eq("b2b_idx", bus.m_idx, 0);
    chk_eq("b2b_busy", bus.busy, 1);
    chk_eq("b2b_overrun", bus.overrun, 0);
    wait_idle();

    // Overrun: acc_done at beat 7 is dropped
    rand_frame();
    pulse_frame(1'b1);
    wait_idx(7);
    rand_frame();
    pulse_frame(1'b0);
    chk_eq("ovr_set", bus.overrun, 1);
    wait_idle();
    chk_eq("ovr_sticky", bus.overrun, 1);

    // Reset mid-frame at beat 9
    rand_frame();
    pulse_frame(1'b1);
    wait_idx(9);
    rst = 1'b1;
    #1;
    chk_eq("mrst_valid", bus.m_valid, 0);
    chk_eq("mrst_data", bus.m_data, 0);
    chk_eq("mrst_idx", bus.m_idx, 0);
    chk_eq("mrst_last", bus.m_last, 0);
    chk_eq("mrst_busy", bus.busy, 0);
    chk_eq("mrst_overrun", bus.overrun, 0);
    exp_d.delete();
    exp_i.delete();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rand_frame();
    pulse_frame(1'b1);
    chk_eq("post_rst_valid", bus.m_valid, 1);
    chk_eq("post_rst_idx", bus.m_idx, 0);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
